// File: rtl/aes_tcdm_responder_if.sv
// Single-word TCDM load/store port between the AES HWPE streamer and its memory.
interface aes_tcdm_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/aes_tcdm_responder.sv
// TCDM word memory answering AES streamer loads/stores, with error flag and accept counter.
// Latency: RESP_LATENCY cycles from accept to r_valid, one response per accept, in order.
// Backpressure: grant withheld one cycle in every STALL_PERIOD; responses cannot be stalled.
module aes_tcdm_responder #(
  parameter int          DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          RESP_LATENCY = 1,
  parameter int          STALL_PERIOD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  aes_tcdm_responder_if.slave  tcdm,
  output logic                 err_o,
  output logic [15:0]          acc_count_o
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          SCW     = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;
  localparam int          SC_LAST = (STALL_PERIOD >= 2) ? STALL_PERIOD - 1 : 0;
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);

  logic [SCW-1:0]          stall_cnt;
  logic                    stall_now;
  logic                    acc;
  logic                    addr_ok;
  logic [31:0]             off;
  logic [31:0]             rd_word;
  logic [AW-1:0]           idx;
  logic [31:0]             mem [DEPTH_WORDS];
  logic [RESP_LATENCY-1:0] pipe_vld;
  logic [31:0]             pipe_dat [RESP_LATENCY];

  assign stall_now = (STALL_PERIOD >= 2) && (stall_cnt == SCW'(SC_LAST));
  assign tcdm.gnt  = tcdm.req & ~stall_now;
  assign acc       = tcdm.req & tcdm.gnt;

  // Offset compare bounds the top end even if BASE_ADDR + SPAN wraps past 2^32.
  assign off     = tcdm.add - BASE_ADDR;
  assign addr_ok = (tcdm.add[1:0] == 2'b00) && (tcdm.add >= BASE_ADDR) && (off < SPAN);
  assign idx     = AW'(off >> 2);
  assign rd_word = !tcdm.wen ? 32'h0 : (addr_ok ? mem[idx] : 32'hDEAD_BEEF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (clear || stall_now) begin
      stall_cnt <= '0;
    end else if (STALL_PERIOD >= 2) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && acc && !clear && !tcdm.wen && addr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (tcdm.be[k]) mem[idx][8*k +: 8] <= tcdm.data[8*k +: 8];
      end
    end
  end

  // Data rides with its valid bit and is forced to zero on idle slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld    <= '0;
      err_o       <= 1'b0;
      acc_count_o <= 16'h0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_dat[i] <= 32'h0;
    end else if (clear) begin
      pipe_vld    <= '0;
      err_o       <= 1'b0;
      acc_count_o <= 16'h0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_dat[i] <= 32'h0;
    end else begin
      pipe_vld[0] <= acc;
      pipe_dat[0] <= acc ? rd_word : 32'h0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      if (acc && !addr_ok) err_o <= 1'b1;
      if (acc && acc_count_o != 16'hFFFF) acc_count_o <= acc_count_o + 16'h1;
    end
  end

  assign tcdm.r_valid = pipe_vld[RESP_LATENCY-1];
  assign tcdm.r_data  = pipe_dat[RESP_LATENCY-1];

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// Directed bench for aes_tcdm_responder: four instances with different latency/stall
// settings share one stimulus bus, selected by sel.
module tb_aes_tcdm_responder;
  logic        clk = 1'b0;
  logic        reset_n, clear_r, req, wen;
  logic [31:0] add, data;
  logic [3:0]  be;
  logic [1:0]  sel;
  logic [3:0]  clr, err;
  logic [15:0] cnt [4];
  logic        gnt, rv;
  logic [31:0] rd;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] rq_d [$];
  int          rq_c [$];
  int          acc_c [$];
  int          w;

  localparam logic [31:0] B0 = 32'h0000_1000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_tcdm_responder_if i0 (), i1 (), i2 (), i3 ();

  assign clr = clear_r ? (4'b0001 << sel) : 4'b0000;
  assign i0.req = req & (sel == 2'd0); assign i0.add = add; assign i0.wen = wen; assign i0.be = be; assign i0.data = data;
  assign i1.req = req & (sel == 2'd1); assign i1.add = add; assign i1.wen = wen; assign i1.be = be; assign i1.data = data;
  assign i2.req = req & (sel == 2'd2); assign i2.add = add; assign i2.wen = wen; assign i2.be = be; assign i2.data = data;
  assign i3.req = req & (sel == 2'd3); assign i3.add = add; assign i3.wen = wen; assign i3.be = be; assign i3.data = data;

  aes_tcdm_responder #(.BASE_ADDR(B0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clr[0]), .tcdm(i0.slave), .err_o(err[0]), .acc_count_o(cnt[0]));
  aes_tcdm_responder #(.RESP_LATENCY(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clr[1]), .tcdm(i1.slave), .err_o(err[1]), .acc_count_o(cnt[1]));
  aes_tcdm_responder #(.STALL_PERIOD(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clr[2]), .tcdm(i2.slave), .err_o(err[2]), .acc_count_o(cnt[2]));
  aes_tcdm_responder #(.RESP_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .clear(clr[3]), .tcdm(i3.slave), .err_o(err[3]), .acc_count_o(cnt[3]));

  always_comb begin
    case (sel)
      2'd0:    begin gnt = i0.gnt; rv = i0.r_valid; rd = i0.r_data; end
      2'd1:    begin gnt = i1.gnt; rv = i1.r_valid; rd = i1.r_data; end
      2'd2:    begin gnt = i2.gnt; rv = i2.r_valid; rd = i2.r_data; end
      default: begin gnt = i3.gnt; rv = i3.r_valid; rd = i3.r_data; end
    endcase
  end

  always @(negedge clk) begin
    if (rv === 1'b1) begin
      rq_d.push_back(rd);
      rq_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    rq_d.delete();
    rq_c.delete();
    acc_c.delete();
  endtask

  // Starts just after a falling edge, returns on the falling edge after the accept.
  task automatic xfer(input logic is_rd, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output int waits);
    req = 1'b1; wen = is_rd; add = a; be = b; data = d; waits = 0;
    #1;
    while (!gnt && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    check("gnt_wait", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1;
    acc_c.push_back(cyc);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_resp(input int i, input logic [31:0] exp_d, input int lat);
    if (rq_d.size() > i) begin
      check("r_data", rq_d[i], exp_d);
      if (acc_c.size() > i) check("r_lat", rq_c[i] - acc_c[i], lat);
    end else begin
      check("r_missing", rq_d.size(), i + 1);
    end
  endtask

  initial begin
    reset_n = 1'b0; clear_r = 1'b0; req = 1'b0; wen = 1'b1;
    add = '0; data = '0; be = '0; sel = 2'd0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      check("rst_rvalid", {31'b0, rv}, 32'd0);
      check("rst_rdata", rd, 32'd0);
      check("rst_err", {31'b0, err[k]}, 32'd0);
      check("rst_cnt", {16'b0, cnt[k]}, 32'd0);
    end

    // Stall period 3: grant drops in cycles 2, 5, 8 after reset.
    sel = 2'd2;
    @(negedge clk);
    reset_n = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h0; be = 4'h0;
    for (int c = 0; c < 9; c++) begin
      #1;
      check("stall_gnt", {31'b0, gnt}, (c % 3 == 2) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    req = 1'b0;
    #1;
    check("stall_cnt", {16'b0, cnt[2]}, 32'd6);

    // Basic write then read, latency 1.
    sel = 2'd0;
    @(negedge clk);
    flush();
    xfer(1'b0, B0 + 32'h10, 4'hF, 32'h0011_2233, w);
    check("gnt_same", w, 0);
    xfer(1'b1, B0 + 32'h10, 4'h0, 32'h0, w);
    check("gnt_same_rd", w, 0);
    repeat (3) @(negedge clk);
    check("basic_nresp", rq_d.size(), 2);
    chk_resp(0, 32'h0, 0);
    chk_resp(1, 32'h0011_2233, 0);
    check("basic_cnt", {16'b0, cnt[0]}, 32'd2);

    // Byte enables.
    flush();
    xfer(1'b0, B0 + 32'hC, 4'hF, 32'hAABB_CCDD, w);
    xfer(1'b0, B0 + 32'hC, 4'b0101, 32'h1122_3344, w);
    xfer(1'b1, B0 + 32'hC, 4'h0, 32'h0, w);
    repeat (3) @(negedge clk);
    chk_resp(2, 32'hAA22_CC44, 0);

    // Out-of-range and misaligned accesses.
    flush();
    xfer(1'b0, B0, 4'hF, 32'hCAFE_F00D, w);
    check("err_clean", {31'b0, err[0]}, 32'd0);
    xfer(1'b1, B0 + 32'h400, 4'h0, 32'h0, w);
    xfer(1'b0, B0 + 32'h2, 4'hF, 32'h0, w);
    xfer(1'b1, B0, 4'h0, 32'h0, w);
    xfer(1'b1, B0 - 32'h4, 4'h0, 32'h0, w);
    repeat (3) @(negedge clk);
    chk_resp(1, 32'hDEAD_BEEF, 0);
    chk_resp(2, 32'h0, 0);
    chk_resp(3, 32'hCAFE_F00D, 0);
    chk_resp(4, 32'hDEAD_BEEF, 0);
    check("err_set", {31'b0, err[0]}, 32'd1);
    check("cnt_pre_clr", {16'b0, cnt[0]}, 32'd10);
    clear_r = 1'b1;
    @(negedge clk);
    clear_r = 1'b0;
    #1;
    check("err_clr", {31'b0, err[0]}, 32'd0);
    check("cnt_clr", {16'b0, cnt[0]}, 32'd0);
    @(negedge clk);
    flush();
    xfer(1'b1, B0, 4'h0, 32'h0, w);
    xfer(1'b1, B0 + 32'h10, 4'h0, 32'h0, w);
    xfer(1'b1, B0 + 32'hC, 4'h0, 32'h0, w);
    repeat (3) @(negedge clk);
    chk_resp(0, 32'hCAFE_F00D, 0);
    chk_resp(1, 32'h0011_2233, 0);
    chk_resp(2, 32'hAA22_CC44, 0);

    // Latency 4, back-to-back reads keep order and spacing.
    sel = 2'd1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) xfer(1'b0, 32'(4 * i), 4'hF, 32'h100 + 32'(i), w);
    repeat (6) @(negedge clk);
    flush();
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'(4 * i), 4'h0, 32'h0, w);
    repeat (8) @(negedge clk);
    check("lat4_nresp", rq_d.size(), 4);
    for (int i = 0; i < 4; i++) chk_resp(i, 32'h100 + 32'(i), 3);
    if (rq_c.size() == 4) begin
      for (int i = 1; i < 4; i++) check("lat4_b2b", rq_c[i] - rq_c[0], i);
    end

    // Latency 3: clear one cycle after accept drops the response.
    sel = 2'd3;
    @(negedge clk);
    xfer(1'b0, 32'h0, 4'hF, 32'h0000_0055, w);
    repeat (5) @(negedge clk);
    flush();
    xfer(1'b1, 32'h0, 4'h0, 32'h0, w);
    clear_r = 1'b1;
    @(negedge clk);
    clear_r = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_drop", rq_d.size(), 0);
    check("clr_cnt", {16'b0, cnt[3]}, 32'd0);

    // Same again, but reset_n kills the response while it is on the output.
    flush();
    xfer(1'b1, 32'h0, 4'h0, 32'h0, w);
    @(negedge clk);
    @(posedge clk); #1;
    check("pre_rst_rv", {31'b0, rv}, 32'd1);
    check("pre_rst_rd", rd, 32'h0000_0055);
    reset_n = 1'b0;
    #1;
    check("rst_async_rv", {31'b0, rv}, 32'd0);
    check("rst_async_rd", rd, 32'd0);
    check("rst_async_cnt", {16'b0, cnt[3]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_drop", rq_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
